regfile_sequencer: RTL and testbench
====================================

Name: regfile_sequencer

Overview:
- Control-side initiator for the 8+1 register file. Drives the file's SA/SB/SD/TA/TB/TD/RW/DDATA ports and consumes its ADATA/BDATA.
- Accepts one macro-op per valid/ready handshake and expands it into 1-3 register-file cycles. Multi-step ops use the hidden temporary register (T, address bit 3 = 1).
- Sits between instruction decode and the register file.

Parameters:
- DW, 8, data width; must match the register-file data width.
- AW, 3, user register index width; T is reached only through TA/TB/TD.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  reset, asynchronous, active-high.
- REQ_VALID  in  1  request present.
- REQ_READY  out  1  sequencer can accept; high only in IDLE.
- OP  in  3  macro-op code, sampled at accept.
- RD  in  AW  destination/first operand index, sampled at accept.
- RS  in  AW  source/second operand index, sampled at accept.
- IMM  in  DW  immediate, sampled at accept.
- BUSY  out  1  high in any EXEC state.
- DONE  out  1  one-cycle pulse when an op has retired.
- SA, SB, SD  out  AW each  register-file A/B/D select.
- TA, TB, TD  out  1 each  temporary-register select for A/B/D.
- RW  out  1  register-file write enable.
- DDATA  out  DW  register-file write data.
- ADATA, BDATA  in  DW each  register-file read data; combinational in the same cycle as the select.
- ZF, CF  out  1 each  flags (see Optional Feature).

Behaviour:
- Reset (asynchronous assert):
  - State goes to IDLE. RW=0, DONE=0, BUSY=0.
  - All select outputs, TA/TB/TD and DDATA go to 0. REQ_READY goes to 1 once RST deasserts. ZF=CF=0.
  - If reset lands mid-op, the op is abandoned. A partial SWAP may leave T or RD modified; this is acceptable.
- States: IDLE, EX1, EX2, EX3.
  - Select, T-bit and RW outputs are decoded from registered state plus captured fields.
  - DDATA is combinational from ADATA/BDATA/IMM.
  - In IDLE all file-drive outputs are 0.
- Accept: REQ_VALID & REQ_READY at an edge captures OP/RD/RS/IMM and moves to EX1.
- Each EX cycle with RW=1 writes the file at the next edge.
- Completion: after the last EX cycle the state returns to IDLE with DONE=1 for that IDLE cycle. A new request may be accepted in the DONE cycle (back-to-back, no bubble).
- Latency:
  - 1-step ops: accept edge k, write edge k+1, DONE high in cycle k+1..k+2.
  - SWAP: 3 write edges, k+1..k+3.
- Ops (results are DW-bit, modulo 2^DW):
  - 000 NOP: EX1 with RW=0, then DONE.
  - 001 MOV: EX1: SA=RS, SD=RD, RW=1, DDATA=ADATA.
  - 010 LDI: EX1: SD=RD, RW=1, DDATA=IMM.
  - 011 SWAP, three cycles:
    - EX1: SA=RD, TD=1, DDATA=ADATA (T<-RD).
    - EX2: SA=RS, SD=RD, DDATA=ADATA (RD<-RS).
    - EX3: TA=1, SD=RS, DDATA=ADATA (RS<-T).
  - 100 ADD: EX1: SA=RD, SB=RS, SD=RD, DDATA=ADATA+BDATA.
  - 101 SUB: EX1 as ADD, DDATA=ADATA-BDATA.
  - 110 ADDI: EX1: SA=RD, SD=RD, DDATA=ADATA+IMM.
  - 111 CLR: EX1: SD=RD, DDATA=0.
- Boundary cases:
  - RD==RS: SWAP still takes 3 cycles and leaves the value unchanged. MOV rewrites the same value. ADD doubles. SUB yields 0.
  - Wrap: 0xFF+0x01 = 0x00. 0x00-0x01 = 0xFF.
  - REQ_VALID while BUSY: ignored (REQ_READY=0); the field inputs need not be held stable.
  - T is never written by any op except SWAP EX1.

Optional Feature:
- Macro: REGSEQ_FLAGS_EN.
- Defined:
  - ZF and CF are registered and update at the write edge of ADD/SUB/ADDI only.
  - ZF=1 iff the written result is 0.
  - CF = carry-out for ADD/ADDI, and borrow for SUB (1 iff ADATA<BDATA unsigned).
  - Other ops leave the flags unchanged. Reset value is 0.
- Not defined: ZF and CF are tied to 0 and no flag logic is generated. The port list is identical in both builds.

Test Plan:
- Reset then LDI R3,0x5A; MOV R4,R3 -> R3=R4=0x5A. DONE pulses 1 cycle after each write edge. REQ_READY=1 in both DONE cycles (back-to-back accepted).
- LDI R1=0x11, R2=0x22; SWAP R1,R2 -> R1=0x22, R2=0x11, T=0x11. BUSY for exactly 3 cycles. RW=1 in EX1-EX3 with TD=1 in EX1 and TA=1 in EX3.
- R5=0xFF; ADDI R5,0x01 -> R5=0x00; with REGSEQ_FLAGS_EN, ZF=1 and CF=1. SUB R6(0x00),R7(0x01) -> R6=0xFF, CF=1, ZF=0.
- SWAP R2,R2 with R2=0x3C -> R2=0x3C, T=0x3C, DONE after 3 writes. Then NOP -> no write edge (RW=0 throughout), DONE pulse.
- Assert RST during SWAP EX2 -> RW=0 and outputs 0 immediately, REQ_READY=1 after release. A following CLR R1 -> R1=0x00.
- REQ_VALID held high with changing OP during a SWAP -> only the first op executes. The next op is accepted in the DONE cycle.

Source files
------------

// File: rtl/regfile_sequencer_if.sv
// Bundle between instruction decode, regfile_sequencer and the 8+1 register file.
// slave = sequencer view; master = decode/register-file side.
interface regfile_sequencer_if #(
  parameter int DW = 8,
  parameter int AW = 3
);
  // Request handshake and op status
  logic          req_valid;
  logic          req_ready;
  logic [2:0]    op;
  logic [AW-1:0] rd;
  logic [AW-1:0] rs;
  logic [DW-1:0] imm;
  logic          busy;
  logic          done;

  // Register-file drive and read-back
  logic [AW-1:0] sa;
  logic [AW-1:0] sb;
  logic [AW-1:0] sd;
  logic          ta;
  logic          tb;
  logic          td;
  logic          rw;
  logic [DW-1:0] ddata;
  logic [DW-1:0] adata;
  logic [DW-1:0] bdata;

  // Flags
  logic          zf;
  logic          cf;

  modport slave (
    input  req_valid, op, rd, rs, imm, adata, bdata,
    output req_ready, busy, done, sa, sb, sd, ta, tb, td, rw, ddata, zf, cf
  );

  modport master (
    output req_valid, op, rd, rs, imm, adata, bdata,
    input  req_ready, busy, done, sa, sb, sd, ta, tb, td, rw, ddata, zf, cf
  );
endinterface

// File: rtl/regfile_sequencer.sv
// Expands one macro-op per handshake into 1-3 register-file cycles (SWAP goes through T).
// Optional macro REGSEQ_FLAGS_EN enables registered ZF/CF updated by ADD/SUB/ADDI.
module regfile_sequencer #(
  parameter int DW = 8,
  parameter int AW = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  regfile_sequencer_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, EX1, EX2, EX3} state_e;

  typedef enum logic [2:0] {
    OP_NOP  = 3'd0,
    OP_MOV  = 3'd1,
    OP_LDI  = 3'd2,
    OP_SWAP = 3'd3,
    OP_ADD  = 3'd4,
    OP_SUB  = 3'd5,
    OP_ADDI = 3'd6,
    OP_CLR  = 3'd7
  } op_e;

  state_e        state;
  op_e           op_q;
  logic [AW-1:0] rd_q;
  logic [AW-1:0] rs_q;
  logic [DW-1:0] imm_q;
  logic          done_q;

  // NOTE: all state below uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      op_q   <= OP_NOP;
      rd_q   <= '0;
      rs_q   <= '0;
      imm_q  <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.req_valid) begin
            state <= EX1;
            op_q  <= op_e'(bus.op);
            rd_q  <= bus.rd;
            rs_q  <= bus.rs;
            imm_q <= bus.imm;
          end
        end
        EX1: begin
          if (op_q == OP_SWAP) begin
            state <= EX2;
          end else begin
            state  <= IDLE;
            done_q <= 1'b1;
          end
        end
        EX2: state <= EX3;
        EX3: begin
          state  <= IDLE;
          done_q <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Held low while reset is asserted so decode never sees a spurious accept window.
  assign bus.req_ready = (state == IDLE) && !rst;
  assign bus.busy      = (state != IDLE);
  assign bus.done      = done_q;

  // NOTE: every output gets a default first so no path through the case
  // statements leaves a value unassigned (which would infer a latch).
  always_comb begin
    bus.sa    = '0;
    bus.sb    = '0;
    bus.sd    = '0;
    bus.ta    = 1'b0;
    bus.tb    = 1'b0;
    bus.td    = 1'b0;
    bus.rw    = 1'b0;
    bus.ddata = '0;
    unique case (state)
      EX1: begin
        unique case (op_q)
          OP_NOP: ;
          OP_MOV: begin
            bus.sa    = rs_q;
            bus.sd    = rd_q;
            bus.rw    = 1'b1;
            bus.ddata = bus.adata;
          end
          OP_LDI: begin
            bus.sd    = rd_q;
            bus.rw    = 1'b1;
            bus.ddata = imm_q;
          end
          OP_SWAP: begin
            bus.sa    = rd_q;
            bus.td    = 1'b1;
            bus.rw    = 1'b1;
            bus.ddata = bus.adata;
          end
          OP_ADD, OP_SUB: begin
            bus.sa    = rd_q;
            bus.sb    = rs_q;
            bus.sd    = rd_q;
            bus.rw    = 1'b1;
            bus.ddata = (op_q == OP_ADD) ? bus.adata + bus.bdata
                                         : bus.adata - bus.bdata;
          end
          OP_ADDI: begin
            bus.sa    = rd_q;
            bus.sd    = rd_q;
            bus.rw    = 1'b1;
            bus.ddata = bus.adata + imm_q;
          end
          OP_CLR: begin
            bus.sd    = rd_q;
            bus.rw    = 1'b1;
          end
          default: ;
        endcase
      end
      EX2: begin
        bus.sa    = rs_q;
        bus.sd    = rd_q;
        bus.rw    = 1'b1;
        bus.ddata = bus.adata;
      end
      EX3: begin
        bus.ta    = 1'b1;
        bus.sd    = rs_q;
        bus.rw    = 1'b1;
        bus.ddata = bus.adata;
      end
      default: ;
    endcase
  end

`ifdef REGSEQ_FLAGS_EN
  logic [DW:0] wide;
  logic        zf_q;
  logic        cf_q;

  // One extra bit carries the ADD/ADDI carry-out or the SUB borrow.
  always_comb begin
    unique case (op_q)
      OP_ADD:  wide = {1'b0, bus.adata} + {1'b0, bus.bdata};
      OP_SUB:  wide = {1'b0, bus.adata} - {1'b0, bus.bdata};
      default: wide = {1'b0, bus.adata} + {1'b0, imm_q};
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      zf_q <= 1'b0;
      cf_q <= 1'b0;
    end else if (state == EX1 &&
                 (op_q == OP_ADD || op_q == OP_SUB || op_q == OP_ADDI)) begin
      zf_q <= (wide[DW-1:0] == '0);
      cf_q <= wide[DW];
    end
  end

  assign bus.zf = zf_q;
  assign bus.cf = cf_q;
`else
  assign bus.zf = 1'b0;
  assign bus.cf = 1'b0;
`endif

endmodule

// File: tb/tb_regfile_sequencer.sv
// Self-checking bench: register-file model on the bus, op-level reference model,
// directed steps followed by randomized macro-ops.
module tb_regfile_sequencer;
  localparam int DW = 8;
  localparam int AW = 3;
`ifdef REGSEQ_FLAGS_EN
  localparam bit FLAGS = 1'b1;
`else
  localparam bit FLAGS = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  regfile_sequencer_if #(.DW(DW), .AW(AW)) bus ();

  regfile_sequencer #(.DW(DW), .AW(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Register file the sequencer drives: 8 user registers plus hidden T.
  logic [7:0] rf [8];
  logic [7:0] rf_t;
  assign bus.adata = bus.ta ? rf_t : rf[bus.sa];
  assign bus.bdata = bus.tb ? rf_t : rf[bus.sb];
  always @(posedge clk) begin
    if (bus.rw) begin
      if (bus.td) rf_t <= bus.ddata;
      else        rf[bus.sd] <= bus.ddata;
    end
  end

  // Reference model state, updated once per macro-op.
  logic [7:0] exp_rf [8];
  logic [7:0] exp_t;
  logic       exp_zf = 1'b0;
  logic       exp_cf = 1'b0;

  int n_vec  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic void model(input logic [2:0] o, input int d, input int s,
                                input logic [7:0] im);
    int a;
    int b;
    int r;
    a = int'(exp_rf[d]);
    b = int'(exp_rf[s]);
    case (o)
      3'd1: exp_rf[d] = exp_rf[s];
      3'd2: exp_rf[d] = im;
      3'd3: begin
        exp_t     = exp_rf[d];
        exp_rf[d] = exp_rf[s];
        exp_rf[s] = exp_t;
      end
      3'd4, 3'd5, 3'd6: begin
        if (o == 3'd4)      r = a + b;
        else if (o == 3'd5) r = a - b + 256;
        else                r = a + int'(im);
        exp_rf[d] = r[7:0];
        if (FLAGS) begin
          exp_zf = (r % 256 == 0);
          exp_cf = (o == 3'd5) ? (a < b) : (r > 255);
        end
      end
      3'd7: exp_rf[d] = 8'h00;
      default: ;
    endcase
  endfunction

  task automatic check_state(input string tag);
    for (int i = 0; i < 8; i++) check($sformatf("%s_r%0d", tag, i), rf[i], exp_rf[i]);
    check({tag, "_t"}, rf_t, exp_t);
    check({tag, "_zf"}, bus.zf, exp_zf);
    check({tag, "_cf"}, bus.cf, exp_cf);
  endtask

  // Called at a negedge; returns at the negedge of the DONE cycle.
  task automatic issue(input logic [2:0] o, input int d, input int s,
                       input logic [7:0] im, input bit hold);
    int cyc;
    int writes;
    int exp_cyc;
    int exp_wr;
    check("ready_at_issue", bus.req_ready, 1);
    bus.req_valid = 1'b1;
    bus.op        = o;
    bus.rd        = 3'(d);
    bus.rs        = 3'(s);
    bus.imm       = im;
    exp_cyc = (o == 3'd3) ? 3 : 1;
    exp_wr  = (o == 3'd3) ? 3 : ((o == 3'd0) ? 0 : 1);
    model(o, d, s, im);
    @(posedge clk);
    #1;
    if (!hold) bus.req_valid = 1'b0;
    cyc    = 0;
    writes = 0;
    while (1) begin
      @(negedge clk);
      if (bus.done) break;
      cyc++;
      check("busy_in_exec", bus.busy, 1);
      check("ready_in_exec", bus.req_ready, 0);
      if (bus.rw) writes++;
      if (o == 3'd3 && cyc == 1) check("swap_ex1_td", bus.td, 1);
      if (o == 3'd3 && cyc == 3) check("swap_ex3_ta", bus.ta, 1);
      if (hold) begin
        bus.op  = 3'($urandom);
        bus.rd  = 3'($urandom);
        bus.rs  = 3'($urandom);
        bus.imm = 8'($urandom);
      end
      if (cyc > 6) begin
        check("done_timeout", cyc, exp_cyc);
        break;
      end
    end
    check("exec_cycles", cyc, exp_cyc);
    check("write_cycles", writes, exp_wr);
    check("done_busy", bus.busy, 0);
    check("done_rw", bus.rw, 0);
    check("done_ready", bus.req_ready, 1);
    check_state($sformatf("op%0d", o));
  endtask

  task automatic idle_cycle();
    bus.req_valid = 1'b0;
    @(negedge clk);
    check("done_one_cycle", bus.done, 0);
    check("idle_busy", bus.busy, 0);
  endtask

  initial begin
    bus.req_valid = 1'b0;
    bus.op        = '0;
    bus.rd        = '0;
    bus.rs        = '0;
    bus.imm       = '0;

    // Reset values while RST is high, then ready after release
    @(negedge clk);
    check("rst_rw", bus.rw, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_ddata", bus.ddata, 0);
    check("rst_sd", bus.sd, 0);
    check("rst_td", bus.td, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rel_ready", bus.req_ready, 1);
    check("rel_zf", bus.zf, 0);
    check("rel_cf", bus.cf, 0);
    @(negedge clk);

    for (int i = 0; i < 8; i++) issue(3'd2, i, 0, 8'($urandom), 1'b0);

    // LDI/MOV back-to-back
    issue(3'd2, 3, 0, 8'h5A, 1'b0);
    issue(3'd1, 4, 3, 8'h00, 1'b0);
    idle_cycle();

    // SWAP R1,R2
    issue(3'd2, 1, 0, 8'h11, 1'b0);
    issue(3'd2, 2, 0, 8'h22, 1'b0);
    issue(3'd3, 1, 2, 8'h00, 1'b0);

    // Wrap cases and flags
    issue(3'd2, 5, 0, 8'hFF, 1'b0);
    issue(3'd6, 5, 0, 8'h01, 1'b0);
    issue(3'd2, 6, 0, 8'h00, 1'b0);
    issue(3'd2, 7, 0, 8'h01, 1'b0);
    issue(3'd5, 6, 7, 8'h00, 1'b0);
    issue(3'd4, 7, 7, 8'h00, 1'b0);
    issue(3'd5, 7, 7, 8'h00, 1'b0);

    // SWAP with itself, then NOP
    issue(3'd2, 2, 0, 8'h3C, 1'b0);
    issue(3'd3, 2, 2, 8'h00, 1'b0);
    issue(3'd0, 0, 0, 8'h00, 1'b0);
    idle_cycle();

    // Reset landing in SWAP EX2: T already holds R1, EX2 write is abandoned
    issue(3'd2, 1, 0, 8'h77, 1'b0);
    check("swaprst_ready", bus.req_ready, 1);
    bus.req_valid = 1'b1;
    bus.op        = 3'd3;
    bus.rd        = 3'd1;
    bus.rs        = 3'd2;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    @(negedge clk);
    check("swaprst_ex1_td", bus.td, 1);
    @(negedge clk);
    check("swaprst_ex2_rw", bus.rw, 1);
    rst = 1'b1;
    #1;
    check("midrst_rw", bus.rw, 0);
    check("midrst_busy", bus.busy, 0);
    check("midrst_done", bus.done, 0);
    check("midrst_ddata", bus.ddata, 0);
    check("midrst_sa", bus.sa, 0);
    check("midrst_sd", bus.sd, 0);
    exp_t  = exp_rf[1];
    exp_zf = 1'b0;
    exp_cf = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_rel_ready", bus.req_ready, 1);
    check_state("midrst");
    issue(3'd7, 1, 0, 8'h00, 1'b0);

    // REQ_VALID held with changing fields during SWAP, next op in DONE cycle
    issue(3'd3, 3, 4, 8'h00, 1'b1);
    issue(3'd4, 3, 4, 8'h00, 1'b0);

    // Randomized macro-ops
    for (int i = 0; i < 60; i++) begin
      issue(3'($urandom_range(0, 7)), $urandom_range(0, 7), $urandom_range(0, 7),
            8'($urandom), (i < 59) && ($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 4) == 0 || i == 59) idle_cycle();
    end

    bus.req_valid = 1'b0;
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
